// File: rtl/seq_mul.sv
// seq_mul: radix-2 shift-add multiplier, one step per clock.
// Signed operands run as magnitudes; the sign is restored when p is written.
module seq_mul #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sign_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [W-1:0]   mcand;
  logic [2*W:0]   acc;
  logic [2*W:0]   acc_nx;
  logic [W:0]     sum;
  logic [CW-1:0]  cnt;
  logic           neg;
  logic           last;
  logic           accept;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [2*W-1:0] prod;

  // -2^(W-1) negates to itself, which is the correct unsigned magnitude
  assign a_mag  = (sign_mode && a[W-1]) ? -a : a;
  assign b_mag  = (sign_mode && b[W-1]) ? -b : b;
  assign last   = (cnt == CW'(W - 1));
  assign accept = start && (state != RUN);

  always_comb begin
    sum    = acc[2*W:W] + {1'b0, (acc[0] ? mcand : '0)};
    acc_nx = {1'b0, sum, acc[W-1:1]};
    prod   = acc_nx[2*W-1:0];
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      p     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        mcand <= a_mag;
        acc   <= {{(W+1){1'b0}}, b_mag};
        cnt   <= '0;
        neg   <= sign_mode & (a[W-1] ^ b[W-1]);
      end else if (state == RUN) begin
        acc <= acc_nx;
        cnt <= cnt + 1'b1;
        if (last) p <= neg ? -prod : prod;
      end
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: directed and random checks of seq_mul at W=8 and W=16
// against an integer-arithmetic reference product.
module tb_seq_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] p8;
  logic        start16, sm16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [31:0] p16;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int starts8 = 0;
  int dones8 = 0;
  int last_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  seq_mul #(.W(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .sign_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
  );

  seq_mul #(.W(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .sign_mode(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .p(p16)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact product as plain integers, truncated to 2w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input bit s);
    longint sx, sy, r;
    sx = longint'(x);
    sy = longint'(y);
    if (s && x[w-1]) sx = sx - (longint'(1) << w);
    if (s && y[w-1]) sy = sy - (longint'(1) << w);
    r = sx * sy;
    return 64'(r) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  always @(negedge clk) begin
    if (done8) begin
      dones8++;
      chk("overlap8", {63'd0, busy8}, 64'd0);
    end
  end

  // Entered and left at a negedge; inputs are scrambled while busy.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb,
                      input bit ts, input bit hold);
    logic [63:0] e;
    logic [15:0] oldp;
    int n;
    e    = ref_mul(8, 32'(ta), 32'(tb), ts);
    oldp = p8;
    a8 = ta; b8 = tb; sm8 = ts; start8 = 1'b1;
    @(posedge clk);
    starts8++;
    @(negedge clk);
    chk("busy_on", {63'd0, busy8}, 64'd1);
    if (!hold) start8 = 1'b0;
    n = 0;
    while (!done8 && n < 12) begin
      chk("p_held", 64'(p8), 64'(oldp));
      a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
      @(negedge clk);
      n++;
    end
    start8 = 1'b0;
    chk("latency8", 64'(n), 64'd8);
    chk("busy_off", {63'd0, busy8}, 64'd0);
    chk("p8", 64'(p8), e & 64'hFFFF);
    last_done = cyc;
  endtask

  task automatic run16(input logic [15:0] ta, input logic [15:0] tb,
                       input bit ts);
    logic [63:0] e;
    int n;
    e = ref_mul(16, 32'(ta), 32'(tb), ts);
    a16 = ta; b16 = tb; sm16 = ts; start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    n = 0;
    while (!done16 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency16", 64'(n), 64'd16);
    chk("p16", 64'(p16), e & 64'hFFFF_FFFF);
  endtask

  initial begin
    int prev;
    bit seen;
    rst = 1'b1;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy8}, 64'd0);
    chk("rst_done", {63'd0, done8}, 64'd0);
    chk("rst_p", 64'(p8), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run8(8'd8, 8'd2, 1'b0, 1'b0);
    @(negedge clk);
    run8(8'd20, 8'd5, 1'b0, 1'b0);
    @(negedge clk);
    run8(8'd255, 8'd255, 1'b0, 1'b0);
    @(negedge clk);
    run8(8'hFD, 8'd5, 1'b1, 1'b0);
    @(negedge clk);
    run8(8'h80, 8'h80, 1'b1, 1'b0);
    @(negedge clk);
    run8(8'h80, 8'h7F, 1'b1, 1'b0);
    @(negedge clk);
    run8(8'd0, 8'h81, 1'b1, 1'b0);
    @(negedge clk);

    // start held and operands churned throughout RUN
    run8(8'd37, 8'hC3, 1'b1, 1'b1);
    @(negedge clk);

    // back-to-back: next start issued in the DONE cycle
    run8(8'd11, 8'd13, 1'b0, 1'b0);
    prev = last_done;
    run8(8'd3, 8'd7, 1'b0, 1'b0);
    chk("b2b_gap", 64'(last_done - prev), 64'd9);

    // abort mid-run with reset
    @(negedge clk);
    a8 = 8'd99; b8 = 8'd77; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", {63'd0, busy8}, 64'd0);
    chk("abort_done", {63'd0, done8}, 64'd0);
    chk("abort_p", 64'(p8), 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    chk("abort_no_done", {63'd0, seen}, 64'd0);
    run8(8'd6, 8'd9, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    run16(16'hFC18, 16'd300, 1'b1);
    run16(16'h8000, 16'h8000, 1'b1);
    run16(16'hFFFF, 16'hFFFF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      run16(16'($urandom), 16'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("done_count", 64'(dones8), 64'(starts8));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
